result_select_stage: RTL and testbench



---
 rtl/result_select_stage_pkg.sv | 34 +++
 rtl/result_select_stage_if.sv | 35 +++
 rtl/result_select_stage_multu_seq.sv | 79 +++++++
 rtl/result_select_stage.sv | 117 +++++++++++
 tb/tb_result_select_stage.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/result_select_stage_pkg.sv
// Shared definitions for the EX result-select stage.
// Holds the R-type funct codes the stage decodes, the default datapath and
// funct widths, the result-source enum used by the output mux and the
// state encoding of the sequential multiplier.
package result_select_stage_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_FUNCT_W = 6;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Where the registered result comes from. SRC_ZERO also means "no GPR write".
    typedef enum logic [2:0] {
        SRC_ALU,
        SRC_SHIFT,
        SRC_HI,
        SRC_LO,
        SRC_ZERO
    } src_e;

    typedef enum logic {
        MUL_IDLE,
        MUL_RUN
    } mul_state_e;

endpackage

// File: rtl/result_select_stage_if.sv
// Handshake bundle between the EX datapath, the result-select stage and the
// EX/MEM register.
//   in side : in_valid/in_ready, funct, alu_out, shift_out, src_a, src_b
//   out side: out_valid/out_ready, data_out, out_wen
// slave  - the result-select stage (consumes ops, produces results)
// master - the surrounding pipeline (issues ops, consumes results)
interface result_select_stage_if
    import result_select_stage_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int FUNCT_W = DEF_FUNCT_W
);
    logic               in_valid;
    logic               in_ready;
    logic [FUNCT_W-1:0] funct;
    logic [WIDTH-1:0]   alu_out;
    logic [WIDTH-1:0]   shift_out;
    logic [WIDTH-1:0]   src_a;
    logic [WIDTH-1:0]   src_b;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_out;
    logic               out_wen;

    modport master (
        output in_valid, funct, alu_out, shift_out, src_a, src_b, out_ready,
        input  in_ready, out_valid, data_out, out_wen
    );

    modport slave (
        input  in_valid, funct, alu_out, shift_out, src_a, src_b, out_ready,
        output in_ready, out_valid, data_out, out_wen
    );
endinterface

// File: rtl/result_select_stage_multu_seq.sv
// multu_seq: unsigned shift-add multiplier, one multiplier bit per cycle.
//   start   in   load a/b and begin (ignored while busy)
//   a, b    in   unsigned operands, WIDTH bits
//   busy    out  multiply in progress (registered)
//   done    out  high during the last RUN cycle; product is valid then
//   product out  full 2*WIDTH-bit result, meaningful while done is high
// The product is presented combinationally in the final cycle so the owner
// can capture it on the same edge that drops busy.
module multu_seq
    import result_select_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int              CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mul_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc_next;

    // NOTE: every signal assigned in always_comb gets a value first on all
    // paths; a missing default would infer a latch.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign busy    = (state == MUL_RUN);
    assign done    = (state == MUL_RUN) && (cnt == LAST);
    assign product = acc_next;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MUL_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        cnt    <= '0;
                        state  <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= MUL_IDLE;
                    end
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/result_select_stage.sv
// result_select_stage: registered EX result mux with valid/ready handshake.
// Selects the EX result by funct into a one-entry output register, owns the
// HI/LO pair and a sequential MULTU so ordinary ops keep flowing while a
// multiply runs.
//   clk, rst_n  clock / asynchronous active-low reset
//   bus         slave side of result_select_stage_if (in/out handshakes)
//   hi_out      current HI
//   lo_out      current LO
//   mul_busy    multiply in progress
module result_select_stage
    import result_select_stage_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int FUNCT_W = DEF_FUNCT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    result_select_stage_if.slave bus,
    output logic [WIDTH-1:0]     hi_out,
    output logic [WIDTH-1:0]     lo_out,
    output logic                 mul_busy
);
    src_e               sel_src;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_wen;
    logic               mul_class;
    logic               slot_free;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic               out_valid_q;
    logic [WIDTH-1:0]   data_q;
    logic               wen_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    always_comb begin
        sel_src = SRC_ZERO;
        case (bus.funct)
            FUNCT_W'(FN_AND),
            FUNCT_W'(FN_OR),
            FUNCT_W'(FN_ADD),
            FUNCT_W'(FN_SUB),
            FUNCT_W'(FN_SLT):  sel_src = SRC_ALU;
            FUNCT_W'(FN_SLL):  sel_src = SRC_SHIFT;
            FUNCT_W'(FN_MFHI): sel_src = SRC_HI;
            FUNCT_W'(FN_MFLO): sel_src = SRC_LO;
            default:           sel_src = SRC_ZERO;
        endcase
    end

    always_comb begin
        sel_data = '0;
        case (sel_src)
            SRC_ALU:   sel_data = bus.alu_out;
            SRC_SHIFT: sel_data = bus.shift_out;
            SRC_HI:    sel_data = hi_q;
            SRC_LO:    sel_data = lo_q;
            default:   sel_data = '0;
        endcase
    end

    assign sel_wen   = (sel_src != SRC_ZERO);

    // Only ops that touch the multiplier or HI/LO wait for it; everything
    // else bypasses a running multiply.
    assign mul_class = (bus.funct == FUNCT_W'(FN_MULTU)) ||
                       (bus.funct == FUNCT_W'(FN_MFHI))  ||
                       (bus.funct == FUNCT_W'(FN_MFLO));

    assign slot_free    = !out_valid_q || bus.out_ready;
    assign bus.in_ready = slot_free && !(mul_busy && mul_class);
    assign accept       = bus.in_valid && bus.in_ready;
    assign mul_start    = accept && (bus.funct == FUNCT_W'(FN_MULTU));

    multu_seq #(.WIDTH(WIDTH)) u_multu (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.src_a),
        .b       (bus.src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            wen_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            // Drain and refill can happen on the same edge; payload only
            // changes on accept so a stalled result stays stable.
            if (slot_free) begin
                out_valid_q <= accept;
                if (accept) begin
                    data_q <= sel_data;
                    wen_q  <= sel_wen;
                end
            end
            if (mul_done) begin
                {hi_q, lo_q} <= mul_product;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_q;
    assign bus.out_wen   = wen_q;
    assign hi_out        = hi_q;
    assign lo_out        = lo_q;
endmodule

// File: tb/tb_result_select_stage.sv
// Directed testbench for result_select_stage. Inputs change just after the
// falling edge; outputs are sampled at the falling edge (or #1 after an input
// change for the combinational in_ready).
module tb_result_select_stage;
    import result_select_stage_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         mul_busy;

    int total = 0;
    int bad   = 0;
    int stall;
    int guard;

    result_select_stage_if #(.WIDTH(W), .FUNCT_W(6)) bus ();

    result_select_stage #(.WIDTH(W), .FUNCT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .mul_busy (mul_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic present(input logic [5:0] f, input logic [W-1:0] alu,
                           input logic [W-1:0] shf, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        bus.in_valid  = 1'b1;
        bus.funct     = f;
        bus.alu_out   = alu;
        bus.shift_out = shf;
        bus.src_a     = a;
        bus.src_b     = b;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.funct     = '0;
        bus.alu_out   = '0;
        bus.shift_out = '0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b1;

        // Reset state
        step();
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst data_out",  64'(bus.data_out),  64'd0);
        check("rst out_wen",   64'(bus.out_wen),   64'd0);
        check("rst hi",        64'(hi_out),        64'd0);
        check("rst lo",        64'(lo_out),        64'd0);
        check("rst mul_busy",  64'(mul_busy),      64'd0);
        rst_n = 1'b1;
        step();

        // ADD then SLL back to back
        present(FN_ADD, 32'h5, 32'h0, 32'h0, 32'h0);
        check("add in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("add valid", 64'(bus.out_valid), 64'd1);
        check("add data",  64'(bus.data_out),  64'h5);
        check("add wen",   64'(bus.out_wen),   64'd1);
        present(FN_SLL, 32'h0, 32'h80, 32'h0, 32'h0);
        check("sll in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("sll data", 64'(bus.data_out), 64'h80);
        check("sll wen",  64'(bus.out_wen),  64'd1);
        bus.in_valid = 1'b0;
        step();
        check("drain valid", 64'(bus.out_valid), 64'd0);

        // MULTU 0xFFFFFFFF x 2 with MFHI presented immediately
        present(FN_MULTU, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h2);
        check("multu in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("multu valid", 64'(bus.out_valid), 64'd1);
        check("multu data",  64'(bus.data_out),  64'd0);
        check("multu wen",   64'(bus.out_wen),   64'd0);
        check("multu busy",  64'(mul_busy),      64'd1);
        present(FN_MFHI, 32'h0, 32'h0, 32'h0, 32'h0);
        check("mul old hi", 64'(hi_out), 64'd0);
        check("mul old lo", 64'(lo_out), 64'd0);
        stall = 0;
        while (!bus.in_ready && stall < 100) begin
            stall++;
            step();
            #1;
        end
        check("mfhi stall cycles", 64'(stall), 64'd32);
        check("prod hi", 64'(hi_out), 64'h1);
        check("prod lo", 64'(lo_out), 64'hFFFF_FFFE);
        step();
        check("mfhi data", 64'(bus.data_out), 64'h1);
        check("mfhi wen",  64'(bus.out_wen),  64'd1);
        present(FN_MFLO, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        check("mflo data", 64'(bus.data_out), 64'hFFFF_FFFE);

        // Non-mul ops flow during a multiply (3 x 5)
        present(FN_MULTU, 32'h0, 32'h0, 32'h3, 32'h5);
        step();
        check("mul2 busy", 64'(mul_busy), 64'd1);
        present(FN_SUB, 32'h7, 32'h0, 32'h0, 32'h0);
        check("sub in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("sub data", 64'(bus.data_out), 64'h7);
        check("sub busy", 64'(mul_busy),     64'd1);
        check("hi held",  64'(hi_out),       64'h1);
        present(FN_OR, 32'hF0, 32'h0, 32'h0, 32'h0);
        check("or in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("or data", 64'(bus.data_out), 64'hF0);
        check("or busy", 64'(mul_busy),     64'd1);
        bus.in_valid = 1'b0;
        guard = 0;
        while (mul_busy && guard < 100) begin
            guard++;
            step();
        end
        check("mul2 timeout", 64'(guard < 100), 64'd1);
        check("mul2 hi", 64'(hi_out), 64'h0);
        check("mul2 lo", 64'(lo_out), 64'hF);

        // Backpressure
        step();
        bus.out_ready = 1'b0;
        present(FN_ADD, 32'h1234, 32'h0, 32'h0, 32'h0);
        step();
        check("bp data0", 64'(bus.data_out), 64'h1234);
        present(FN_SUB, 32'h55, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("bp in_ready", 64'(bus.in_ready),  64'd0);
            check("bp valid",    64'(bus.out_valid), 64'd1);
            check("bp data",     64'(bus.data_out),  64'h1234);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("bp next data", 64'(bus.data_out), 64'h55);
        bus.in_valid = 1'b0;
        step();

        // Reset in the middle of a multiply
        present(FN_MULTU, 32'h0, 32'h0, 32'h10, 32'h10);
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        check("pre-rst busy", 64'(mul_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst valid", 64'(bus.out_valid), 64'd0);
        check("arst data",  64'(bus.data_out),  64'd0);
        check("arst wen",   64'(bus.out_wen),   64'd0);
        check("arst hi",    64'(hi_out),        64'd0);
        check("arst lo",    64'(lo_out),        64'd0);
        check("arst busy",  64'(mul_busy),      64'd0);
        step();
        rst_n = 1'b1;
        step();
        present(FN_MFLO, 32'h0, 32'h0, 32'h0, 32'h0);
        check("post-rst in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("post-rst mflo valid", 64'(bus.out_valid), 64'd1);
        check("post-rst mflo data",  64'(bus.data_out),  64'd0);
        bus.in_valid = 1'b0;
        repeat (30) step();
        check("aborted lo", 64'(lo_out),   64'd0);
        check("aborted hi", 64'(hi_out),   64'd0);
        check("aborted busy", 64'(mul_busy), 64'd0);

        // Unknown funct
        present(6'h3F, 32'hDEAD, 32'h0, 32'h0, 32'h0);
        step();
        check("unk valid", 64'(bus.out_valid), 64'd1);
        check("unk data",  64'(bus.data_out),  64'd0);
        check("unk wen",   64'(bus.out_wen),   64'd0);
        bus.in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
